// File: rtl/spmm_pkg.sv
// Shared types and sizing for the SpMM LHS encoder path.
package spmm_pkg;
  localparam int N     = 16;
  localparam int W     = 8;
  localparam int LGN   = $clog2(N);
  localparam int DBLGN = 2 * $clog2(N);

  typedef logic [W-1:0] data_t;

  typedef struct packed {
    logic [LGN-1:0] col;
    data_t          data;
  } entry_t;

  typedef enum logic [1:0] {CAPTURE, WAIT, SEND} enc_state_t;
endpackage

// File: rtl/row_compactor.sv
// Combinational row compaction: gathers the nonzeros of a dense row to the front,
// tagging each with its column, and reports how many there are.
module row_compactor
  import spmm_pkg::*;
(
  input  data_t  [N-1:0]        row,
  output logic   [N-1:0][LGN:0] prefix,
  output entry_t [N-1:0]        packed_row,
  output logic   [LGN:0]        count
);

  logic [LGN:0] run;

  // prefix[j] counts nonzeros strictly left of column j, which is also j's packed slot
  always_comb begin
    run        = '0;
    prefix     = '0;
    packed_row = '0;
    for (int j = 0; j < N; j++) begin
      prefix[j] = run;
      if (row[j] != '0) begin
        packed_row[run[LGN-1:0]] = '{col: LGN'(j), data: row[j]};
        run = run + 1'b1;
      end
    end
    count = run;
  end

endmodule

// File: rtl/spmm_lhs_encoder.sv
// Dense-to-CSR LHS transmitter: captures N rows, then streams row pointers plus
// N-wide beats of {col, data} into the SpMM LHS port.
module spmm_lhs_encoder
  import spmm_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  data_t [N-1:0]              row_data,
  input  logic                       lhs_ready,
  output logic                       lhs_start,
  output logic                       lhs_valid,
  output logic                       lhs_last,
  output logic  [N-1:0][DBLGN-1:0]   lhs_ptr,
  output logic  [N-1:0][LGN-1:0]     lhs_col,
  output data_t [N-1:0]              lhs_data,
  output logic  [DBLGN:0]            nnz,
  output logic                       busy
);

  enc_state_t state_reg, state_next;
  logic [LGN-1:0] row_cnt_reg, beat_reg, beat_sel, beat_last_idx;
  logic [DBLGN:0] nnz_reg, nnz_sum, nnz_round;
  logic [LGN:0] ceil_beats, beat_total;
  logic row_ready_reg, lhs_start_reg, lhs_valid_reg, lhs_last_reg;
  logic [N-1:0][DBLGN-1:0] ptr_reg;
  logic [N-1:0][LGN-1:0] col_reg, beat_col;
  data_t [N-1:0] data_reg, beat_data;
  entry_t buf_mem [N*N];

  logic [N-1:0][LGN:0] row_prefix;
  entry_t [N-1:0] row_packed;
  logic [LGN:0] row_count;
  logic prefix_unused;
  logic accept;

  row_compactor u_compactor (
    .row        (row_data),
    .prefix     (row_prefix),
    .packed_row (row_packed),
    .count      (row_count)
  );

  assign prefix_unused = ^row_prefix;
  assign accept     = (state_reg == CAPTURE) && row_valid && row_ready_reg;
  assign nnz_sum    = nnz_reg + (DBLGN+1)'(row_count);
  assign nnz_round  = nnz_reg + (DBLGN+1)'(N-1);
  assign ceil_beats = nnz_round[DBLGN:LGN];
  // An empty matrix still sends one all-padding beat
  assign beat_total    = (ceil_beats == '0) ? (LGN+1)'(1) : ceil_beats;
  assign beat_last_idx = LGN'(beat_total - 1'b1);
  assign beat_sel      = (state_reg == WAIT) ? '0 : beat_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CAPTURE: if (accept && row_cnt_reg == LGN'(N-1)) state_next = WAIT;
      WAIT:    if (lhs_ready) state_next = SEND;
      SEND:    if (lhs_last_reg) state_next = CAPTURE;
      default: state_next = CAPTURE;
    endcase
  end

  // Slots at or beyond nnz hold stale data from earlier matrices and are masked to zero
  always_comb begin
    beat_col  = '0;
    beat_data = '0;
    for (int j = 0; j < N; j++) begin
      if ({1'b0, beat_sel, LGN'(j)} < nnz_reg) begin
        beat_col[j]  = buf_mem[{beat_sel, LGN'(j)}].col;
        beat_data[j] = buf_mem[{beat_sel, LGN'(j)}].data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int j = 0; j < N; j++) begin
        if ((LGN+1)'(j) < row_count)
          buf_mem[nnz_reg[DBLGN-1:0] + DBLGN'(j)] <= row_packed[j];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= CAPTURE;
      row_cnt_reg   <= '0;
      beat_reg      <= '0;
      nnz_reg       <= '0;
      row_ready_reg <= 1'b1;
      lhs_start_reg <= 1'b0;
      lhs_valid_reg <= 1'b0;
      lhs_last_reg  <= 1'b0;
      ptr_reg       <= '0;
      col_reg       <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      row_ready_reg <= (state_next == CAPTURE);
      case (state_reg)
        CAPTURE: begin
          if (accept) begin
            ptr_reg[row_cnt_reg] <= nnz_sum[DBLGN-1:0];
            nnz_reg              <= nnz_sum;
            row_cnt_reg          <= row_cnt_reg + 1'b1;
          end
        end
        WAIT: begin
          if (lhs_ready) begin
            lhs_valid_reg <= 1'b1;
            lhs_start_reg <= 1'b1;
            lhs_last_reg  <= (beat_last_idx == '0);
            col_reg       <= beat_col;
            data_reg      <= beat_data;
            beat_reg      <= LGN'(1);
          end
        end
        SEND: begin
          lhs_start_reg <= 1'b0;
          if (lhs_last_reg) begin
            lhs_valid_reg <= 1'b0;
            lhs_last_reg  <= 1'b0;
            col_reg       <= '0;
            data_reg      <= '0;
            nnz_reg       <= '0;
            row_cnt_reg   <= '0;
            beat_reg      <= '0;
          end else begin
            lhs_last_reg <= (beat_reg == beat_last_idx);
            col_reg      <= beat_col;
            data_reg     <= beat_data;
            beat_reg     <= beat_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign row_ready = row_ready_reg;
  assign lhs_start = lhs_start_reg;
  assign lhs_valid = lhs_valid_reg;
  assign lhs_last  = lhs_last_reg;
  assign lhs_ptr   = ptr_reg;
  assign lhs_col   = col_reg;
  assign lhs_data  = data_reg;
  assign nnz       = nnz_reg;
  assign busy      = (state_reg != CAPTURE);

endmodule

// File: tb/tb_spmm_lhs_encoder.sv
// Scoreboard bench: expected CSR beats are computed from the dense matrix and
// queued at issue time; a negedge monitor compares every presented beat.
module tb_spmm_lhs_encoder;
  import spmm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic row_valid = 1'b0;
  logic row_ready;
  data_t [N-1:0] row_data = '0;
  logic lhs_ready = 1'b0;
  logic lhs_start, lhs_valid, lhs_last, busy;
  logic [N-1:0][DBLGN-1:0] lhs_ptr;
  logic [N-1:0][LGN-1:0] lhs_col;
  data_t [N-1:0] lhs_data;
  logic [DBLGN:0] nnz;

  spmm_lhs_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_valid (lhs_valid),
    .lhs_last  (lhs_last),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data),
    .nnz       (nnz),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic                    start;
    logic                    last;
    logic [N-1:0][LGN-1:0]   col;
    logic [N-1:0][W-1:0]     data;
    logic [N-1:0][DBLGN-1:0] ptr;
    logic [DBLGN:0]          nnz;
  } beat_t;

  beat_t exp_q[$];
  logic [N-1:0][W-1:0]     cur_mat [N];
  logic [N-1:0][DBLGN-1:0] exp_ptr;
  logic [DBLGN:0]          exp_nnz;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: row-major nonzero list, cumulative pointers, beats of N slots
  function automatic void build_expect(input int push_limit);
    int cols[$];
    int vals[$];
    int n, nb, idx;
    beat_t b;
    exp_ptr = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cur_mat[r][c] != 0) begin
          cols.push_back(c);
          vals.push_back(int'(cur_mat[r][c]));
        end
      end
      exp_ptr[r] = DBLGN'(cols.size());
    end
    n = cols.size();
    exp_nnz = (DBLGN+1)'(n);
    nb = (n == 0) ? 1 : (n + N - 1) / N;
    for (int k = 0; k < nb; k++) begin
      if (push_limit == 0 || k < push_limit) begin
        b.start = (k == 0);
        b.last  = (k == nb - 1);
        b.ptr   = exp_ptr;
        b.nnz   = exp_nnz;
        b.col   = '0;
        b.data  = '0;
        for (int j = 0; j < N; j++) begin
          idx = k * N + j;
          if (idx < n) begin
            b.col[j]  = LGN'(cols[idx]);
            b.data[j] = W'(vals[idx]);
          end
        end
        exp_q.push_back(b);
      end
    end
  endfunction

  // push_limit > 0: only that many beats are expected, then reset aborts the send
  task automatic run_matrix(input int gap, input int ready_delay, input int push_limit);
    int c;
    build_expect(push_limit);
    lhs_ready = (ready_delay == 0);
    for (int r = 0; r < N; r++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        row_valid = 1'b0;
      end
      @(negedge clock);
      chk("row_ready_capture", row_ready, 1);
      row_valid = 1'b1;
      row_data  = cur_mat[r];
    end
    @(negedge clock);
    row_valid = 1'b0;
    row_data  = '0;
    chk("row_ready_wait", row_ready, 0);
    chk("busy_wait", busy, 1);
    chk("nnz_wait", nnz, exp_nnz);
    chk("ptr_wait", lhs_ptr, exp_ptr);
    for (int d = 0; d < ready_delay; d++) begin
      chk("no_beat_before_ready", lhs_valid, 0);
      chk("row_ready_held_low", row_ready, 0);
      @(negedge clock);
    end
    lhs_ready = 1'b1;
    @(negedge clock);
    chk("start_latency", lhs_start, 1);
    if (push_limit > 0) begin
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_row_ready", row_ready, 1);
      chk("rst_valid", {lhs_valid, lhs_start, lhs_last, busy}, 0);
      chk("rst_col_data", {lhs_col, lhs_data}, 0);
      chk("rst_ptr_nnz", {lhs_ptr, nnz}, 0);
      @(negedge clock);
      reset = 1'b0;
      chk("abort_queue", exp_q.size(), 0);
    end else begin
      c = 0;
      while (c < 40 && !(exp_q.size() == 0 && row_ready)) begin
        @(negedge clock);
        c++;
      end
      chk("drain", {31'd0, exp_q.size() == 0 && row_ready === 1'b1}, 1);
    end
  endtask

  // Monitor: pops one expectation per valid beat; idle outputs must be zero
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (lhs_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", lhs_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_start", lhs_start, e.start);
            chk("beat_last", lhs_last, e.last);
            chk("beat_col", lhs_col, e.col);
            chk("beat_data", lhs_data, e.data);
            chk("beat_ptr", lhs_ptr, e.ptr);
            chk("beat_nnz", nnz, e.nnz);
          end
        end else begin
          chk("idle_zero", {lhs_start, lhs_last, lhs_col, lhs_data}, 0);
        end
      end
    end
  end

  task automatic set_scn3();
    for (int r = 0; r < N; r++) cur_mat[r] = '0;
    for (int c = 0; c < N; c++) begin
      cur_mat[0][c] = 8'd7;
      cur_mat[1][c] = 8'd7;
    end
    cur_mat[2][5] = 8'd3;
  endtask

  initial begin
    int p;
    repeat (3) @(negedge clock);
    chk("reset_row_ready", row_ready, 1);
    chk("reset_outputs", {lhs_valid, lhs_start, lhs_last, busy, nnz}, 0);
    chk("reset_ptr", lhs_ptr, 0);
    reset = 1'b0;

    for (int r = 0; r < N; r++) begin
      cur_mat[r] = '0;
      cur_mat[r][r] = 8'd1;
    end
    run_matrix(0, 0, 0);

    for (int r = 0; r < N; r++) cur_mat[r] = '0;
    run_matrix(0, 0, 0);

    set_scn3();
    run_matrix(0, 0, 0);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) cur_mat[r][c] = 8'd1;
    run_matrix(0, 0, 0);

    set_scn3();
    run_matrix(3, 5, 0);

    set_scn3();
    run_matrix(0, 0, 1);
    for (int r = 0; r < N; r++) cur_mat[r] = '0;
    run_matrix(0, 0, 0);
    for (int r = 0; r < N; r++) begin
      cur_mat[r] = '0;
      cur_mat[r][r] = 8'd1;
    end
    run_matrix(0, 0, 0);

    for (int m = 0; m < 8; m++) begin
      p = $urandom_range(0, 100);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          cur_mat[r][c] = ($urandom_range(0, 99) < p) ? W'($urandom_range(1, 255)) : '0;
      run_matrix($urandom_range(0, 2), $urandom_range(0, 4), 0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
